// File: rtl/motor_cmd_master_pkg.sv
// Shared register map, control bit positions, FSM states and request record for the motor command master.
// Helper functions turn one channel's request into the high-duration and control words.
package motor_pkg;

    localparam logic [1:0] REG_TOTAL_DUR = 2'd0;
    localparam logic [1:0] REG_HIGH_DUR  = 2'd1;
    localparam logic [1:0] REG_CONTROL   = 2'd2;

    localparam int CTRL_GO         = 0;
    localparam int CTRL_FWD        = 1;
    localparam int CTRL_FAST_DECAY = 2;

    typedef enum logic [1:0] {
        S_INIT,
        S_SCAN,
        S_WR_HIGH,
        S_WR_CTRL
    } state_t;

    // speed is carried at 32 bits so the record is independent of SPEED_W
    typedef struct packed {
        logic        brake;
        logic        run;
        logic        dir;
        logic [31:0] speed;
    } motor_req_t;

    function automatic logic [31:0] high_dur(motor_req_t r, logic [31:0] period);
        if (r.brake)
            return '0;
        else if (r.speed > period)
            return period;
        else
            return r.speed;
    endfunction

    function automatic logic [31:0] ctrl_word(motor_req_t r);
        logic [31:0] w;
        w                  = '0;
        w[CTRL_GO]         = r.run;
        w[CTRL_FWD]        = r.dir;
        w[CTRL_FAST_DECAY] = r.brake;
        return w;
    endfunction

endpackage

// File: rtl/motor_cmd_master_write_port.sv
// Avalon-MM write-only port: a one-cycle req_vld loads address/data; done pulses with the completing edge.
// Latency: cs rises the cycle after req_vld; waitrequest stalls with address/data held; a req at done reloads back-to-back.
module avmm_write_port #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_vld,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_dat,
    input  logic              waitrequest,
    output logic              cs,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writedata,
    output logic              done
);

    assign done = cs & write & ~waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs        <= 1'b0;
            write     <= 1'b0;
            address   <= '0;
            writedata <= '0;
        end else if (req_vld && (!cs || done)) begin
            cs        <= 1'b1;
            write     <= 1'b1;
            address   <= req_addr;
            writedata <= req_dat;
        end else if (done) begin
            cs    <= 1'b0;
            write <= 1'b0;
        end
    end

endmodule

// File: rtl/motor_cmd_master.sv
// Programs PWM period on every channel, then rescans and rewrites high duration + control on request change.
// Build option MOTOR_BRAKE_EN adds a per-channel brake input (fast decay, forces high duration to 0).
import motor_pkg::*;

module motor_cmd_master #(
    parameter int NUM_CH  = 2,
    parameter int SPEED_W = 16,
    parameter int PERIOD  = 7000,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ADDR_W = CH_W + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         run,
    input  logic [NUM_CH-1:0]         dir,
`ifdef MOTOR_BRAKE_EN
    input  logic [NUM_CH-1:0]         brake,
`endif
    input  logic [NUM_CH*SPEED_W-1:0] speed,
    output logic                      s_cs,
    output logic [ADDR_W-1:0]         s_address,
    output logic                      s_write,
    output logic                      s_read,
    output logic [31:0]               s_writedata,
    input  logic                      waitrequest,
    output logic                      init_done,
    output logic                      busy
);

    localparam logic [31:0] PERIOD_W = 32'(PERIOD);

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   next_ch;
    logic              pend;
    logic              wr_req_vld;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [31:0]       wr_req_dat;
    logic              wr_done;
    logic [NUM_CH-1:0] valid;
    motor_req_t        shadow [NUM_CH];
    motor_req_t        hold;
    motor_req_t        cur;

    always_comb begin
        cur       = '0;
        cur.run   = run[ch];
        cur.dir   = dir[ch];
        cur.speed = 32'(speed[ch*SPEED_W +: SPEED_W]);
`ifdef MOTOR_BRAKE_EN
        cur.brake = brake[ch];
`endif
    end

    assign next_ch = (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;

    // pend marks a write handed to the port; its done pulse advances the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_INIT;
            ch          <= '0;
            pend        <= 1'b0;
            wr_req_vld  <= 1'b0;
            wr_req_addr <= '0;
            wr_req_dat  <= '0;
            init_done   <= 1'b0;
            valid       <= '0;
            hold        <= '0;
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else begin
            wr_req_vld <= 1'b0;
            case (state)
                S_INIT: begin
                    if (!pend) begin
                        wr_req_vld  <= 1'b1;
                        wr_req_addr <= {ch, REG_TOTAL_DUR};
                        wr_req_dat  <= PERIOD_W;
                        pend        <= 1'b1;
                    end else if (wr_done) begin
                        pend <= 1'b0;
                        ch   <= next_ch;
                        if (ch == CH_W'(NUM_CH - 1)) begin
                            init_done <= 1'b1;
                            state     <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (!valid[ch] || cur != shadow[ch]) begin
                        hold  <= cur;
                        state <= S_WR_HIGH;
                    end else begin
                        ch <= next_ch;
                    end
                end
                S_WR_HIGH: begin
                    if (!pend) begin
                        wr_req_vld  <= 1'b1;
                        wr_req_addr <= {ch, REG_HIGH_DUR};
                        wr_req_dat  <= high_dur(hold, PERIOD_W);
                        pend        <= 1'b1;
                    end else if (wr_done) begin
                        pend  <= 1'b0;
                        state <= S_WR_CTRL;
                    end
                end
                S_WR_CTRL: begin
                    if (!pend) begin
                        wr_req_vld  <= 1'b1;
                        wr_req_addr <= {ch, REG_CONTROL};
                        wr_req_dat  <= ctrl_word(hold);
                        pend        <= 1'b1;
                    end else if (wr_done) begin
                        pend       <= 1'b0;
                        shadow[ch] <= hold;
                        valid[ch]  <= 1'b1;
                        ch         <= next_ch;
                        state      <= S_SCAN;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    avmm_write_port #(.ADDR_W(ADDR_W)) u_wr (
        .clk         (clk),
        .reset       (reset),
        .req_vld     (wr_req_vld),
        .req_addr    (wr_req_addr),
        .req_dat     (wr_req_dat),
        .waitrequest (waitrequest),
        .cs          (s_cs),
        .write       (s_write),
        .address     (s_address),
        .writedata   (s_writedata),
        .done        (wr_done)
    );

    assign s_read = 1'b0;
    assign busy   = s_cs;

endmodule
